// File: rtl/wb_seq_pkg.sv
// Shared types and constants for the Wishbone host sequencer: command encodings,
// FSM states, bus addresses and the address map helper.
package wb_seq_pkg;

    typedef enum logic [1:0] {
        OP_LOAD_W   = 2'b00,
        OP_LOAD_D   = 2'b01,
        OP_READ_RES = 2'b10,
        OP_READ_ID  = 2'b11
    } op_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WRITE,
        S_RD_A,
        S_RD_B,
        S_RD_GAP,
        S_DONE
    } state_t;

    localparam logic [7:0] W_BASE = 8'h51;
    localparam logic [7:0] D_LO   = 8'hC0;
    localparam logic [7:0] D_HI   = 8'hC8;
    localparam logic [7:0] RES    = 8'hA0;
    localparam logic [7:0] ID0    = 8'h81;

    localparam int W_WORDS   = 3;
    localparam int D_WORDS   = 2;
    localparam int RES_WORDS = 1;
    localparam int ID_WORDS  = 3;

    function automatic logic [1:0] last_k(input op_t op);
        case (op)
            OP_LOAD_W:   return 2'(W_WORDS - 1);
            OP_LOAD_D:   return 2'(D_WORDS - 1);
            OP_READ_RES: return 2'(RES_WORDS - 1);
            default:     return 2'(ID_WORDS - 1);
        endcase
    endfunction

    // Bus address of word k of a command; weights use three consecutive slots per engine.
    function automatic logic [7:0] seq_addr(input op_t op, input logic [2:0] sel,
                                            input logic [1:0] k);
        case (op)
            OP_LOAD_W:   return W_BASE + ({6'd0, sel[1:0]} * 8'd3) + {6'd0, k};
            OP_LOAD_D:   return ((k == 2'd0) ? D_LO : D_HI) | {5'd0, sel};
            OP_READ_RES: return RES;
            default:     return ID0 + {6'd0, k};
        endcase
    endfunction

endpackage

// File: rtl/wb_host_sequencer_if.sv
// Bus bundle of the sequencer: the Wishbone master signals and the incoming write-word stream.
interface wb_host_sequencer_if;
    // Stream: a word moves in the cycle where s_valid && s_ready; s_data must be stable while
    // s_valid is high. Wishbone: a write ends in the cycle where cyc && str && we && ack; reads
    // are never acknowledged and use fixed two-cycle timing.
    logic        cyc;
    logic        str;
    logic        we;
    logic [7:0]  addr;
    logic [31:0] data_out;
    logic [31:0] data_in;
    logic        ack;
    logic        s_valid;
    logic [31:0] s_data;
    logic        s_ready;

    modport master (
        output cyc, str, we, addr, data_out, s_ready,
        input  data_in, ack, s_valid, s_data
    );

    modport slave (
        input  cyc, str, we, addr, data_out, s_ready,
        output data_in, ack, s_valid, s_data
    );
endinterface

// File: rtl/wb_ack_timer.sv
// Saturating count of unacknowledged write cycles; flags the last permitted cycle.
module wb_ack_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic expired
);
    localparam int W = $clog2(TIMEOUT + 1);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != W'(TIMEOUT))) begin
            count <= count + W'(1);
        end
    end

    // High during the TIMEOUT-th waiting cycle, so the FSM aborts at the end of that cycle.
    assign expired = (count >= W'(TIMEOUT - 1));
endmodule

// File: rtl/wb_host_sequencer.sv
// Command sequencer: LOAD_W/LOAD_D stream words into Wishbone writes, READ_RES/READ_ID issue
// fixed-timing Wishbone reads returned as r_valid pulses.
module wb_host_sequencer
    import wb_seq_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [1:0]          op,
    input  logic [2:0]          sel,
    wb_host_sequencer_if.master bus,
    output logic                r_valid,
    output logic [31:0]         r_data,
    output logic                busy,
    output logic                done,
    output logic                err,
    output state_t              dbg_state
);
    state_t      state, state_nx;
    op_t         op_r;
    logic [2:0]  sel_r;
    logic [1:0]  k, k_inc;
    logic        err_r;
    logic [7:0]  addr_q;
    logic [31:0] data_out_q;
    logic        cyc_c, we_c, s_ready_c;
    logic        tmr_clr, tmr_inc, tmr_expired;

    assign k_inc   = (k == 2'd3) ? k : k + 2'd1;
    assign tmr_clr = (state == S_FETCH) && bus.s_valid;
    assign tmr_inc = (state == S_WRITE);

    wb_ack_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (tmr_clr),
        .inc     (tmr_inc),
        .expired (tmr_expired)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        cyc_c     = 1'b0;
        we_c      = 1'b0;
        s_ready_c = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        err       = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) state_nx = op[1] ? S_RD_A : S_FETCH;
            end
            S_FETCH: begin
                s_ready_c = 1'b1;
                if (bus.s_valid) state_nx = S_WRITE;
            end
            S_WRITE: begin
                cyc_c = 1'b1;
                we_c  = 1'b1;
                if (bus.ack)          state_nx = (k == last_k(op_r)) ? S_DONE : S_FETCH;
                else if (tmr_expired) state_nx = S_DONE;
            end
            S_RD_A: begin
                cyc_c    = 1'b1;
                state_nx = S_RD_B;
            end
            S_RD_B: begin
                cyc_c    = 1'b1;
                state_nx = (k == last_k(op_r)) ? S_DONE : S_RD_GAP;
            end
            S_RD_GAP: state_nx = S_RD_A;
            S_DONE: begin
                done     = 1'b1;
                err      = err_r;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Address is loaded one cycle ahead of each bus access and otherwise holds.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_r       <= OP_LOAD_W;
            sel_r      <= 3'd0;
            k          <= 2'd0;
            err_r      <= 1'b0;
            addr_q     <= 8'd0;
            data_out_q <= 32'd0;
            r_data     <= 32'd0;
            r_valid    <= 1'b0;
        end else begin
            r_valid <= (state == S_RD_B);
            case (state)
                S_IDLE: if (start) begin
                    op_r  <= op_t'(op);
                    sel_r <= sel;
                    k     <= 2'd0;
                    err_r <= 1'b0;
                    if (op[1]) addr_q <= seq_addr(op_t'(op), sel, 2'd0);
                end
                S_FETCH: if (bus.s_valid) begin
                    data_out_q <= bus.s_data;
                    addr_q     <= seq_addr(op_r, sel_r, k);
                end
                S_WRITE: begin
                    if (bus.ack)          k     <= k_inc;
                    else if (tmr_expired) err_r <= 1'b1;
                end
                S_RD_B: begin
                    r_data <= bus.data_in;
                    k      <= k_inc;
                end
                S_RD_GAP: addr_q <= seq_addr(op_r, sel_r, k);
                default: ;
            endcase
        end
    end

    assign bus.cyc      = cyc_c;
    assign bus.str      = cyc_c;
    assign bus.we       = we_c;
    assign bus.addr     = addr_q;
    assign bus.data_out = data_out_q;
    assign bus.s_ready  = s_ready_c;
    assign dbg_state    = state;
endmodule

// File: tb/tb_wb_host_sequencer.sv
// Bench for wb_host_sequencer: command table, hand-written reset sequence and random commands,
// all checked against a transaction-level model of the bus traffic.
module tb_wb_host_sequencer;
    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 start = 1'b0;
    logic [1:0]           op = 2'b00;
    logic [2:0]           sel = 3'd0;
    logic                 r_valid, busy, done, err;
    logic [31:0]          r_data;
    wb_seq_pkg::state_t   dbg_state;

    wb_host_sequencer_if ifc ();

    wb_host_sequencer #(.TIMEOUT(15)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .sel       (sel),
        .bus       (ifc.master),
        .r_valid   (r_valid),
        .r_data    (r_data),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    function void check(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endfunction

    // ---------------- slave model ----------------
    localparam logic [15:0] OUTA = 16'h1234;
    localparam logic [15:0] OUTB = 16'h5678;

    function automatic logic [31:0] slave_rd(input logic [7:0] a);
        case (a)
            8'h81:   return 32'h414D5331;
            8'h82:   return 32'h43454149;
            8'h83:   return 32'h322E3030;
            8'hA0:   return {OUTB, OUTA};
            default: return {24'hBAD000, a};
        endcase
    endfunction

    int wcnt = 0;
    int ack_delay = 0;
    bit ack_never = 1'b0;

    always @(posedge clk) begin
        if (ifc.cyc && ifc.we && !ifc.ack) wcnt <= wcnt + 1;
        else                               wcnt <= 0;
    end

    assign ifc.ack     = ifc.cyc && ifc.str && ifc.we && !ack_never && (wcnt >= ack_delay);
    assign ifc.data_in = slave_rd(ifc.addr);

    // ---------------- stream driver ----------------
    logic [31:0] word_q[$];
    int          gap_q[$];
    int          gap_cnt = 0;
    bit          hs = 1'b0;

    always @(posedge clk) hs <= ifc.s_valid && ifc.s_ready;

    initial begin
        ifc.s_valid = 1'b0;
        ifc.s_data  = 32'd0;
        forever begin
            @(negedge clk);
            if (hs && ifc.s_valid && word_q.size() > 0) begin
                void'(word_q.pop_front());
                void'(gap_q.pop_front());
                ifc.s_valid = 1'b0;
                gap_cnt     = 0;
            end
            if (!ifc.s_valid && word_q.size() > 0) begin
                if (gap_cnt < gap_q[0]) gap_cnt++;
                else begin
                    ifc.s_valid = 1'b1;
                    ifc.s_data  = word_q[0];
                end
            end
        end
    end

    task automatic flush_stream();
        word_q.delete();
        gap_q.delete();
        ifc.s_valid = 1'b0;
        gap_cnt     = 0;
    endtask

    // ---------------- scoreboard / monitor ----------------
    logic [39:0] exp_q[$];
    logic [31:0] exp_rd_q[$];
    logic [7:0]  exp_rda_q[$];
    int          done_cnt = 0, err_cnt = 0, wr_cycles = 0, wr_seen = 0;
    bit          prev_cyc = 1'b0, first_seen = 1'b0;
    logic [7:0]  first_addr = 8'd0;

    always @(negedge clk) begin
        if (rst) begin
            if (ifc.cyc && !prev_cyc) begin
                if (!first_seen) begin
                    first_addr = ifc.addr;
                    first_seen = 1'b1;
                end
                if (!ifc.we) begin
                    if (exp_rda_q.size() == 0) check("rd_access_unexpected", {56'd0, ifc.addr}, 64'd0);
                    else check("rd_addr", {56'd0, ifc.addr}, {56'd0, exp_rda_q.pop_front()});
                end
            end
            if (ifc.cyc && ifc.we) wr_cycles++;
            if (ifc.cyc && ifc.str && ifc.we && ifc.ack) begin
                wr_seen++;
                if (exp_q.size() == 0) check("wr_unexpected", {24'd0, ifc.addr, ifc.data_out}, 64'd0);
                else check("wr_addr_data", {24'd0, ifc.addr, ifc.data_out}, {24'd0, exp_q.pop_front()});
            end
            if (r_valid) begin
                if (exp_rd_q.size() == 0) check("rvalid_unexpected", {32'd0, r_data}, 64'd0);
                else check("r_data", {32'd0, r_data}, {32'd0, exp_rd_q.pop_front()});
            end
            if (ifc.s_ready) check("cyc_low_in_fetch", {63'd0, ifc.cyc}, 64'd0);
            if (err) check("err_with_done", {63'd0, done}, 64'd1);
            if (done) done_cnt++;
            if (err)  err_cnt++;
            prev_cyc = ifc.cyc;
        end else begin
            prev_cyc = 1'b0;
        end
    end

    // ---------------- reference model ----------------
    function automatic logic [7:0] model_waddr(input logic [1:0] op_i, input logic [2:0] sel_i,
                                               input int k);
        if (op_i == 2'b00) return 8'(8'h51 + 3 * int'(sel_i[1:0]) + k);
        return 8'(((k == 0) ? 8'hC0 : 8'hC8) + int'(sel_i));
    endfunction

    function automatic logic [7:0] model_raddr(input logic [1:0] op_i, input int k);
        if (op_i == 2'b10) return 8'hA0;
        return 8'(8'h81 + k);
    endfunction

    task automatic run_cmd(input logic [1:0] op_i, input logic [2:0] sel_i,
                           input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                           input int gap, input int ack_dly, input bit ack_off, input bit hold,
                           input bit exp_err);
        logic [31:0] ws[3];
        int n, budget;
        ws = '{w0, w1, w2};
        done_cnt = 0; err_cnt = 0; wr_cycles = 0; first_seen = 1'b0;
        ack_delay = ack_dly; ack_never = ack_off;
        if (!op_i[1]) begin
            n = op_i[0] ? 2 : 3;
            for (int i = 0; i < n; i++) begin
                word_q.push_back(ws[i]);
                gap_q.push_back(gap);
                if (!ack_off) exp_q.push_back({model_waddr(op_i, sel_i, i), ws[i]});
            end
        end else begin
            n = op_i[0] ? 3 : 1;
            for (int i = 0; i < n; i++) begin
                exp_rda_q.push_back(model_raddr(op_i, i));
                exp_rd_q.push_back(slave_rd(model_raddr(op_i, i)));
            end
        end
        @(negedge clk);
        start = 1'b1; op = op_i; sel = sel_i;
        if (!hold) begin
            @(negedge clk);
            start = 1'b0;
        end
        budget = 0;
        while (done_cnt == 0 && budget < 300) begin
            @(negedge clk); #1;
            budget++;
        end
        start = 1'b0;
        check("done_seen", {63'd0, done_cnt != 0}, 64'd1);
        check("err_at_done", {63'd0, err}, {63'd0, exp_err});
        check("cyc_at_done", {63'd0, ifc.cyc}, 64'd0);
        flush_stream();
        @(negedge clk); #1;
        check("busy_after_done", {63'd0, busy}, 64'd0);
        if (ack_off) check("timeout_write_cycles", wr_cycles, 15);
        repeat (3) @(negedge clk);
        #1;
        check("done_count", done_cnt, 1);
        check("err_count", err_cnt, {63'd0, exp_err});
        check("wr_left", exp_q.size(), 0);
        check("rd_left", exp_rd_q.size() + exp_rda_q.size(), 0);
        exp_q.delete(); exp_rd_q.delete(); exp_rda_q.delete();
    endtask

    // ---------------- command table ----------------
    typedef struct {
        logic [1:0]  op;
        logic [2:0]  sel;
        logic [31:0] w0, w1, w2;
        int          gap;
        int          ack_dly;
        bit          ack_off;
        bit          hold;
        logic [7:0]  exp_a0;
        bit          exp_err;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int budget;
        bit     aoff;
        logic [1:0] rop;

        vecs[0] = '{2'b00, 3'd2, 32'h11111111, 32'h22222222, 32'hAB000000, 0, 0, 1'b0, 1'b0, 8'h57, 1'b0};
        vecs[1] = '{2'b01, 3'd5, 32'hDEADBEEF, 32'h01234567, 32'd0,        3, 0, 1'b0, 1'b0, 8'hC5, 1'b0};
        vecs[2] = '{2'b11, 3'd0, 32'd0, 32'd0, 32'd0,                       0, 0, 1'b0, 1'b0, 8'h81, 1'b0};
        vecs[3] = '{2'b10, 3'd3, 32'd0, 32'd0, 32'd0,                       0, 0, 1'b0, 1'b1, 8'hA0, 1'b0};
        vecs[4] = '{2'b00, 3'd0, $urandom, $urandom, $urandom,              1, 2, 1'b0, 1'b0, 8'h51, 1'b0};
        vecs[5] = '{2'b00, 3'd7, $urandom, $urandom, $urandom,              0, 1, 1'b0, 1'b0, 8'h5A, 1'b0};
        vecs[6] = '{2'b01, 3'd0, $urandom, $urandom, 32'd0,                 2, 3, 1'b0, 1'b0, 8'hC0, 1'b0};
        vecs[7] = '{2'b00, 3'd1, $urandom, $urandom, $urandom,              0, 0, 1'b1, 1'b0, 8'h54, 1'b1};

        // reset state
        #12;
        check("rst_cyc", {63'd0, ifc.cyc}, 64'd0);
        check("rst_str", {63'd0, ifc.str}, 64'd0);
        check("rst_we", {63'd0, ifc.we}, 64'd0);
        check("rst_s_ready", {63'd0, ifc.s_ready}, 64'd0);
        check("rst_flags", {60'd0, r_valid, busy, done, err}, 64'd0);
        check("rst_addr", {56'd0, ifc.addr}, 64'd0);
        check("rst_data_out", {32'd0, ifc.data_out}, 64'd0);
        check("rst_r_data", {32'd0, r_data}, 64'd0);
        @(negedge clk); #2 rst = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_cmd(vecs[i].op, vecs[i].sel, vecs[i].w0, vecs[i].w1, vecs[i].w2, vecs[i].gap,
                    vecs[i].ack_dly, vecs[i].ack_off, vecs[i].hold, vecs[i].exp_err);
            check("first_addr", {56'd0, first_addr}, {56'd0, vecs[i].exp_a0});
        end

        // reset during the second weight write, then a clean LOAD_W from word 0
        ack_delay = 4; ack_never = 1'b0; wr_seen = 0;
        for (int i = 0; i < 3; i++) begin
            word_q.push_back(32'hC0DE0000 + 32'(i));
            gap_q.push_back(0);
            exp_q.push_back({model_waddr(2'b00, 3'd1, i), 32'hC0DE0000 + 32'(i)});
        end
        @(negedge clk);
        start = 1'b1; op = 2'b00; sel = 3'd1;
        @(negedge clk);
        start = 1'b0;
        budget = 0;
        while (!(wr_seen >= 1 && ifc.cyc && ifc.we) && budget < 100) begin
            @(negedge clk); #1;
            budget++;
        end
        check("reached_word1_write", {63'd0, wr_seen >= 1 && ifc.cyc && ifc.we}, 64'd1);
        rst = 1'b0;
        #1;
        check("midrst_cyc", {63'd0, ifc.cyc}, 64'd0);
        check("midrst_busy", {63'd0, busy}, 64'd0);
        check("midrst_data_out", {32'd0, ifc.data_out}, 64'd0);
        check("midrst_addr", {56'd0, ifc.addr}, 64'd0);
        flush_stream();
        exp_q.delete();
        @(negedge clk); #2 rst = 1'b1;
        run_cmd(2'b00, 3'd1, 32'h0A0A0A0A, 32'h0B0B0B0B, 32'h0C0C0C0C, 0, 0, 1'b0, 1'b0, 1'b0);
        check("after_rst_first_addr", {56'd0, first_addr}, 64'h54);

        // random commands against the model
        for (int i = 0; i < 20; i++) begin
            rop  = 2'($urandom_range(0, 3));
            aoff = (rop[1] == 1'b0) && ($urandom_range(0, 7) == 0);
            run_cmd(rop, 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
                    $urandom_range(0, 2), $urandom_range(0, 3), aoff, 1'b0, aoff);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/wb_host_sequencer.md
WB_HOST_SEQUENCER -- requirements
Module: wb_host_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, meaning the maximum number of cycles a write waits for ack before aborting.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-low (asserted at 0).
REQ-004 SHALL have port start  input  1  a command request, sampled only in IDLE.
REQ-005 SHALL have port op  input  2  command: 00 LOAD_W, 01 LOAD_D, 10 READ_RES, 11 READ_ID.
REQ-006 SHALL have port sel  input  3  LOAD_W uses sel[1:0] as the engine index; LOAD_D uses sel[2:0] as the lane.
REQ-007 SHALL have port s_valid / s_data / s_ready  input 1 / input 32 / output 1  the write-word stream.
REQ-008 SHALL have port cyc, str, we  output  1 each  Wishbone master controls.
REQ-009 SHALL have port addr  output  8  Wishbone address.
REQ-010 SHALL have port data_out  output  32  Wishbone write data.
REQ-011 SHALL have port data_in  input  32  Wishbone read data.
REQ-012 SHALL have port ack  input  1  Wishbone acknowledge, valid for writes only.
REQ-013 SHALL have port r_valid / r_data  output 1 / output 32  a single-cycle pulse carrying each read word.
REQ-014 SHALL have ports busy, done, err  output  1 each  status; done and err are one-cycle pulses.

Function
REQ-015 SHALL implement the FSM states IDLE, FETCH, WRITE, RD_A, RD_B and DONE.
REQ-016 IDLE: when start=1, SHALL latch op and sel, clear the word index k, and go to FETCH for op 0x/01, or to RD_A for op 1x.
REQ-017 FETCH: s_ready=1; when s_valid=1, SHALL capture s_data into data_out and go to WRITE; s_ready SHALL be 0 in every other state.
REQ-018 WRITE: cyc=str=we=1, with addr as follows:
- LOAD_W: 0x51 + 3*sel[1:0] + k, for k = 0..2.
- LOAD_D: 0xC0|sel for k=0; 0xC8|sel for k=1.
REQ-019 WRITE: on ack=1, SHALL increment k and go to DONE if k was the last word (LOAD_W k=2, LOAD_D k=1), otherwise back to FETCH; cyc/str SHALL drop for at least the FETCH cycle.
REQ-020 A weight word k=2 SHALL be written unmodified; the slave uses only bits [31:24].
REQ-021 A timeout counter SHALL clear on entry to WRITE; if TIMEOUT cycles pass without ack, the block SHALL deassert cyc/str/we, pulse err and done together, and return to IDLE.
REQ-022 Reads (no ack) SHALL use a fixed timing:
- RD_A: cyc=str=1, we=0 for one cycle.
- RD_B: holds the same signals and captures data_in at the end of the cycle.
- After RD_B, r_valid pulses with r_data.
REQ-023 READ_RES SHALL perform one read at addr 0xA0; READ_ID SHALL perform three reads at 0x81, 0x82, 0x83, with cyc low for one cycle between reads.
REQ-024 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-025 busy SHALL be 1 in every state except IDLE.
REQ-026 start SHALL be ignored while busy=1, with no queuing.
REQ-027 When not in WRITE/RD_A/RD_B, addr SHALL hold its last value and cyc=str=we=0.
REQ-028 The k counter and the timeout counter SHALL saturate and never wrap.

Reset
REQ-029 When rst=0, the FSM SHALL go to IDLE immediately (asynchronously) and cyc, str, we, s_ready, r_valid, busy, done, err SHALL be 0.
REQ-030 On reset, addr, data_out, r_data, k and the timeout counter SHALL be 0.
REQ-031 Reset mid-transaction SHALL abandon the command; any stream word already captured is lost.

Structure
REQ-032 Package wb_seq_pkg SHALL hold:
- the op encodings;
- the FSM state type;
- the address constants W_BASE=0x51, D_LO=0xC0, D_HI=0xC8, RES=0xA0, ID0=0x81;
- the words-per-op constants.
REQ-033 Sub-module wb_ack_timer (a TIMEOUT-wide saturating counter with clear input and expiry output) SHALL be used for REQ-021.

Verification
REQ-034 LOAD_W, sel=2, stream 0x11111111/0x22222222/0xAB000000, slave acks same cycle -> writes to 0x57, 0x58, 0x59 with those data; done once; err=0.
REQ-035 LOAD_D, sel=5, words 0xDEADBEEF then 0x01234567, s_valid delayed 3 cycles per word -> cyc low while waiting; writes 0xC5=0xDEADBEEF, 0xCD=0x01234567.
REQ-036 READ_ID against the slave model -> three r_valid pulses: 0x414D5331, 0x43454149, 0x322E3030.
REQ-037 LOAD_W with ack held 0 -> cyc drops after 15 WRITE cycles; err=done=1 for one cycle; busy=0 the next cycle.
REQ-038 start held high during READ_RES -> exactly one read at 0xA0; r_data={outb,outa}.
REQ-039 rst=0 pulse during LOAD_W word 1 -> cyc=0 within the same cycle; a following LOAD_W completes normally, starting from k=0.
